// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_seq_pkg
//  Description : Shared types and constants for the ALU command sequencer.
//                Defines the sequencer state encoding, the queued command
//                record and the ALU function codes, plus a small helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

    // Sequencer states. The enum documents the encoding; the RTL uses the
    // explicit-width localparams below so the state register stays a plain
    // logic vector.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

    // One queued command: load flag, ALU function code and operand.
    typedef struct packed {
        logic       load;
        logic [2:0] op;
        logic [7:0] operand;
    } cmd_t;

    // ALU function codes (value of f on the ALU).
    localparam logic [2:0] OP_ADD     = 3'b000;
    localparam logic [2:0] OP_ADD_SHL = 3'b001;
    localparam logic [2:0] OP_SEL     = 3'b010;
    localparam logic [2:0] OP_ADD_SHR = 3'b011;
    localparam logic [2:0] OP_ZERO    = 3'b100;
    localparam logic [2:0] OP_OR      = 3'b101;
    localparam logic [2:0] OP_AND     = 3'b110;
    localparam logic [2:0] OP_SHL     = 3'b111;

    // Zero flag for values that bypass the ALU (accumulator loads).
    function automatic logic is_zero(input logic [7:0] value);
        return (value == 8'h00);
    endfunction

endpackage : alu_seq_pkg
`default_nettype wire

// File: rtl/alu_cmd_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : alu_cmd_fifo
//  Description : Synchronous command FIFO of DEPTH cmd_t entries with
//                registered occupancy count. Push is ignored when full and
//                pop is ignored when empty; a full FIFO never bypasses, even
//                when a pop happens in the same cycle.
//  Ports       : clk, rst_n        - clock, async active-low reset
//                push, push_data   - write request and entry
//                pop, pop_data     - read request and current head entry
//                full, empty       - status decoded from the registered count
//                count             - number of valid entries (0..DEPTH)
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_fifo
    import alu_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  cmd_t                      push_data,
    input  logic                      pop,
    output cmd_t                      pop_data,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    cmd_t            r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    logic            w_push;
    logic            w_pop;

    assign full     = (r_count == CW'(DEPTH));
    assign empty    = (r_count == '0);
    assign count    = r_count;
    assign pop_data = r_mem[r_rd_ptr];

    // Qualified requests: full/empty come from the registered count only.
    assign w_push = push & ~full;
    assign w_pop  = pop  & ~empty;

    // Storage needs no reset: entries are only read once counted valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : alu_cmd_fifo
`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_cmd_sequencer
//  Description : Multi-cycle command front end for an 8-bit combinational
//                ALU. Queues {load, op, operand} commands, drives the ALU
//                with a = accumulator, b = operand, f = op, captures the
//                result into the accumulator and a result register, and
//                presents each result on a valid/ready channel.
//  Ports       : clk, rst_n                 - clock, async active-low reset
//                cmd_valid/cmd_ready        - command handshake
//                cmd_load/cmd_op/cmd_operand- command fields
//                alu_a/alu_b/alu_f          - registered ALU inputs
//                alu_w/alu_c/alu_z          - ALU result, carry, zero
//                res_valid/res_ready        - result handshake
//                res_data/res_c/res_z       - result value and flags
//                acc                        - current accumulator
//                busy                       - work in flight or queued
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    // command channel
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_load,
    input  logic [2:0] cmd_op,
    input  logic [7:0] cmd_operand,
    // ALU interface
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [2:0] alu_f,
    input  logic [7:0] alu_w,
    input  logic       alu_c,
    input  logic       alu_z,
    // result channel
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic       res_c,
    output logic       res_z,
    // status
    output logic [7:0] acc,
    output logic       busy
);

    logic [1:0]               r_state;
    logic                     r_load;

    cmd_t                     w_push_cmd;
    cmd_t                     w_head;
    logic                     w_fifo_full;
    logic                     w_fifo_empty;
    logic [$clog2(DEPTH):0]   w_fifo_count;
    logic                     w_push;
    logic                     w_pop;

    // ------------------------------------------------------------------
    // Command queue
    // ------------------------------------------------------------------
    assign w_push_cmd = '{load: cmd_load, op: cmd_op, operand: cmd_operand};
    assign cmd_ready  = ~w_fifo_full;
    assign w_push     = cmd_valid & cmd_ready;

    // A new command starts either from IDLE or directly on the result
    // handshake, which is what gives one result every two cycles.
    assign w_pop = ~w_fifo_empty &
                   ((r_state == ST_IDLE) |
                    ((r_state == ST_RESP) & res_valid & res_ready));

    alu_cmd_fifo #(
        .DEPTH     (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .push_data (w_push_cmd),
        .pop       (w_pop),
        .pop_data  (w_head),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .count     (w_fifo_count)
    );

    assign busy = (r_state != ST_IDLE) | (w_fifo_count != '0);

    // ------------------------------------------------------------------
    // Sequencer FSM, ALU input registers, accumulator and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_load    <= 1'b0;
            alu_a     <= 8'h00;
            alu_b     <= 8'h00;
            alu_f     <= 3'b000;
            acc       <= 8'h00;
            res_valid <= 1'b0;
            res_data  <= 8'h00;
            res_c     <= 1'b0;
            res_z     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        alu_a   <= acc;
                        alu_b   <= w_head.operand;
                        alu_f   <= w_head.op;
                        r_load  <= w_head.load;
                        r_state <= ST_ISSUE;
                    end
                end

                // The ALU has had one full cycle to settle on alu_a/b/f.
                ST_ISSUE: begin
                    if (r_load) begin
                        // Loads bypass the ALU entirely; flags are derived
                        // locally so a stale ALU output cannot leak in.
                        acc      <= alu_b;
                        res_data <= alu_b;
                        res_c    <= 1'b0;
                        res_z    <= is_zero(alu_b);
                    end else begin
                        acc      <= alu_w;
                        res_data <= alu_w;
                        res_c    <= alu_c;
                        res_z    <= alu_z;
                    end
                    res_valid <= 1'b1;
                    r_state   <= ST_RESP;
                end

                ST_RESP: begin
                    if (res_valid && res_ready) begin
                        res_valid <= 1'b0;
                        if (w_pop) begin
                            // acc already holds this result, so chaining
                            // uses the freshly updated value.
                            alu_a   <= acc;
                            alu_b   <= w_head.operand;
                            alu_f   <= w_head.op;
                            r_load  <= w_head.load;
                            r_state <= ST_ISSUE;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end

                default: begin
                    r_state   <= ST_IDLE;
                    res_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule : alu_cmd_sequencer
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_cmd_sequencer
//  Description : Self-checking bench for alu_cmd_sequencer with a behavioural
//                8-bit ALU attached. Expected results are computed when each
//                command is accepted and queued; a monitor pops and compares
//                them on every result handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_sequencer;
    import alu_seq_pkg::*;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_load = 1'b0;
    logic [2:0] cmd_op = 3'b000;
    logic [7:0] cmd_operand = 8'h00;
    logic [7:0] alu_a, alu_b;
    logic [2:0] alu_f;
    logic [7:0] alu_w;
    logic       alu_c, alu_z;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [7:0] res_data;
    logic       res_c, res_z;
    logic [7:0] acc;
    logic       busy;

    logic       force_z0 = 1'b0;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_load    (cmd_load),
        .cmd_op      (cmd_op),
        .cmd_operand (cmd_operand),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_f       (alu_f),
        .alu_w       (alu_w),
        .alu_c       (alu_c),
        .alu_z       (alu_z),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_c       (res_c),
        .res_z       (res_z),
        .acc         (acc),
        .busy        (busy)
    );

    // Behavioural ALU: returns {c, z, w}.
    function automatic logic [9:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic [2:0] f);
        logic [8:0] s;
        logic [7:0] w;
        logic       c;
        s = {1'b0, a} + {1'b0, b};
        w = 8'h00;
        c = 1'b0;
        case (f)
            OP_ADD:     begin w = s[7:0];          c = s[8]; end
            OP_ADD_SHL: begin w = {s[6:0], 1'b0};  c = s[7]; end
            OP_SEL:     begin w = b;               c = 1'b0; end
            OP_ADD_SHR: begin w = s[8:1];          c = s[0]; end
            OP_ZERO:    begin w = 8'h00;           c = 1'b0; end
            OP_OR:      begin w = a | b;           c = 1'b0; end
            OP_AND:     begin w = a & b;           c = 1'b0; end
            default:    begin w = {a[6:0], 1'b0};  c = a[7]; end
        endcase
        return {c, (w == 8'h00), w};
    endfunction

    logic [9:0] alu_out;
    assign alu_out = alu_fn(alu_a, alu_b, alu_f);
    assign alu_w   = alu_out[7:0];
    assign alu_z   = alu_out[8] & ~force_z0;
    assign alu_c   = alu_out[9];

    typedef struct packed {
        logic [7:0] d;
        logic       c;
        logic       z;
    } res_t;

    res_t       exp_q[$];
    int         hs_q[$];
    logic [7:0] acc_m = 8'h00;
    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;
    int         last_push_cyc = 0;
    logic       hold_seen = 1'b0;
    res_t       hold_v;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Result monitor: one negedge with valid & ready == one handshake.
    always @(negedge clk) begin
        res_t e;
        if (!rst_n) begin
            hold_seen = 1'b0;
        end else if (res_valid && res_ready) begin
            hold_seen = 1'b0;
            if (exp_q.size() == 0) begin
                check_val("spurious_res_valid", {31'b0, res_valid}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_val("res_data", {24'b0, res_data}, {24'b0, e.d});
                check_val("res_c", {31'b0, res_c}, {31'b0, e.c});
                check_val("res_z", {31'b0, res_z}, {31'b0, e.z});
                check_val("acc_track", {24'b0, acc}, {24'b0, e.d});
                hs_q.push_back(cyc);
            end
        end else if (res_valid) begin
            if (hold_seen) begin
                check_val("res_hold", {21'b0, res_data, res_c, res_z}, {21'b0, hold_v});
            end
            hold_v    = '{d: res_data, c: res_c, z: res_z};
            hold_seen = 1'b1;
        end else begin
            hold_seen = 1'b0;
        end
    end

    // Call at posedge+#1; returns at posedge+#1 after acceptance.
    task automatic push_cmd(input logic ld, input logic [2:0] op, input logic [7:0] v);
        int         n;
        res_t       e;
        logic [9:0] r;
        n = 0;
        cmd_valid   = 1'b1;
        cmd_load    = ld;
        cmd_op      = op;
        cmd_operand = v;
        @(negedge clk);
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            check_val("push_timeout", {31'b0, cmd_ready}, 32'd1);
            @(posedge clk); #1;
            cmd_valid = 1'b0;
            return;
        end
        if (ld) begin
            e = '{d: v, c: 1'b0, z: (v == 8'h00)};
        end else begin
            r = alu_fn(acc_m, v, op);
            e = '{d: r[7:0], c: r[9], z: r[8]};
        end
        acc_m = e.d;
        exp_q.push_back(e);
        @(posedge clk); #1;
        last_push_cyc = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check_val("drain_remaining", exp_q.size(), 32'd0);
        check_val("drain_busy", {31'b0, busy}, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic check_spacing(input string tag, input int n_exp);
        check_val({tag, "_hs_count"}, hs_q.size(), n_exp);
        for (int i = 1; i < hs_q.size(); i++) begin
            check_val({tag, "_spacing"}, hs_q[i] - hs_q[i-1], 32'd2);
        end
    endtask

    initial begin
        int first_push;
        int n;

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        check_val("rst_busy", {31'b0, busy}, 32'd0);
        check_val("rst_res_valid", {31'b0, res_valid}, 32'd0);
        check_val("rst_acc", {24'b0, acc}, 32'd0);
        check_val("rst_alu", {13'b0, alu_a, alu_b, alu_f}, 32'd0);
        check_val("rst_res", {22'b0, res_data, res_c, res_z}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ---------------- load then add, latency/throughput ----------------
        res_ready = 1'b1;
        hs_q.delete();
        push_cmd(1'b1, OP_ADD, 8'h10);
        first_push = last_push_cyc;
        push_cmd(1'b0, OP_ADD, 8'h05);
        wait_drain();
        check_spacing("t1", 2);
        if (hs_q.size() >= 1) check_val("t1_latency", hs_q[0] - first_push, 32'd2);
        check_val("t1_acc", {24'b0, acc}, 32'h15);
        check_val("t1_alu_regs", {13'b0, alu_a, alu_b, alu_f}, {13'b0, 8'h10, 8'h05, OP_ADD});

        // ---------------- carry out ----------------
        push_cmd(1'b1, OP_ADD, 8'hF0);
        push_cmd(1'b0, OP_ADD, 8'h20);
        wait_drain();
        check_val("t2_acc", {24'b0, acc}, 32'h10);

        // ---------------- zero flag via AND, then OR ----------------
        push_cmd(1'b1, OP_ADD, 8'h0F);
        push_cmd(1'b0, OP_AND, 8'h30);
        push_cmd(1'b0, OP_OR,  8'h81);
        wait_drain();
        check_val("t3_acc", {24'b0, acc}, 32'h81);

        // ---------------- backpressure, full queue, in-order drain ----------------
        res_ready = 1'b0;
        push_cmd(1'b1, OP_ADD,     8'h01);
        push_cmd(1'b0, OP_ADD,     8'h02);
        push_cmd(1'b0, OP_ADD_SHL, 8'h03);
        push_cmd(1'b0, OP_SEL,     8'h44);
        push_cmd(1'b0, OP_ADD_SHR, 8'h7F);
        @(negedge clk);
        check_val("t4_full_ready", {31'b0, cmd_ready}, 32'd0);
        check_val("t4_busy", {31'b0, busy}, 32'd1);
        repeat (4) @(negedge clk);
        check_val("t4_still_full", {31'b0, cmd_ready}, 32'd0);
        @(posedge clk); #1;
        hs_q.delete();
        res_ready = 1'b1;
        wait_drain();
        check_spacing("t4", 5);
        check_val("t4_ready_after", {31'b0, cmd_ready}, 32'd1);

        // ---------------- reset in ISSUE with two commands queued ----------------
        res_ready = 1'b0;
        push_cmd(1'b1, OP_ADD, 8'h33);
        push_cmd(1'b0, OP_ADD, 8'h01);
        push_cmd(1'b0, OP_ADD, 8'h02);
        push_cmd(1'b0, OP_ADD, 8'h03);
        n = 0;
        @(negedge clk);
        while (!res_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_val("t5_first_valid", {31'b0, res_valid}, 32'd1);
        @(posedge clk); #1;
        res_ready = 1'b1;
        @(negedge clk);            // monitor consumes the first result here
        @(posedge clk); #1;        // handshake edge: now in ISSUE, two queued
        rst_n = 1'b0;
        #1;
        check_val("t5_rst_acc", {24'b0, acc}, 32'd0);
        check_val("t5_rst_res_valid", {31'b0, res_valid}, 32'd0);
        check_val("t5_rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        check_val("t5_rst_busy", {31'b0, busy}, 32'd0);
        check_val("t5_rst_alu", {13'b0, alu_a, alu_b, alu_f}, 32'd0);
        exp_q.delete();
        acc_m = 8'h00;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check_val("t5_no_result", {31'b0, res_valid}, 32'd0);
        check_val("t5_idle", {31'b0, busy}, 32'd0);
        @(posedge clk); #1;

        // ---------------- load zero with ALU zero flag forced low ----------------
        force_z0 = 1'b1;
        push_cmd(1'b1, OP_OR, 8'h00);
        wait_drain();
        force_z0 = 1'b0;
        check_val("t6_acc", {24'b0, acc}, 32'd0);

        // ---------------- remaining functions and wrap-around ----------------
        push_cmd(1'b1, OP_ADD,  8'h81);
        push_cmd(1'b0, OP_SHL,  8'h00);
        push_cmd(1'b0, OP_ZERO, 8'h5A);
        push_cmd(1'b1, OP_ADD,  8'hFF);
        push_cmd(1'b0, OP_ADD,  8'h01);
        wait_drain();
        check_val("t7_acc", {24'b0, acc}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, got running, expected done");
        $fatal(1, "timeout");
    end

endmodule : tb_alu_cmd_sequencer
`default_nettype wire

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Multi-cycle command front end for the 8-bit combinational ALU (`ALU_2`, ports a, b, f, w, c, z).
- Buffers incoming {load, op, operand} commands in a small FIFO and holds an 8-bit accumulator.
- Drives the ALU with a = accumulator, b = operand, f = op, then captures w/c/z into the accumulator and a result register.
- Presents each result on a valid/ready output channel. Sits directly upstream (operand/opcode source) and downstream (result/flag sink) of the ALU.

Parameters:
- DEPTH, 4, command FIFO entries; power of two, 2..16.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO can accept
- cmd_load  in  1  1 = load operand into accumulator; 0 = ALU op
- cmd_op  in  3  ALU function code f
- cmd_operand  in  8  ALU b operand / load value
- alu_a  out  8  registered ALU a (accumulator copy)
- alu_b  out  8  registered ALU b
- alu_f  out  3  registered ALU f
- alu_w  in  8  ALU result
- alu_c  in  1  ALU carry
- alu_z  in  1  ALU zero flag
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_data  out  8  result value
- res_c  out  1  result carry
- res_z  out  1  result zero
- acc  out  8  current accumulator
- busy  out  1  state != IDLE or FIFO non-empty

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; FIFO empty; acc=0.
  - alu_a/alu_b/alu_f=0.
  - res_valid=0, res_data=0, res_c=0, res_z=0.
  - cmd_ready=1, busy=0.
  - Any in-flight or queued command is dropped.
- Command push: cmd_valid & cmd_ready at an edge writes the entry.
  - cmd_ready = !full from the registered count.
  - No bypass when full, even if a pop happens in the same cycle.
- States: IDLE, ISSUE, RESP.
- IDLE: if the FIFO is non-empty at an edge:
  - pop the head;
  - load alu_a=acc, alu_b=operand, alu_f=op, latch the load bit;
  - go to ISSUE.
- ISSUE: exactly one cycle; the ALU settles combinationally. At the next edge:
  - ALU op (load=0): res_data=acc=alu_w, res_c=alu_c, res_z=alu_z.
  - Load (load=1): res_data=acc=alu_b, res_c=0, res_z=(alu_b==0); ALU outputs ignored.
  - res_valid<=1; go to RESP.
- RESP: hold res_* stable while res_ready=0. On res_valid & res_ready at an edge:
  - FIFO non-empty: pop and reload the ALU regs from the updated acc; go to ISSUE; res_valid<=0.
  - FIFO empty: go to IDLE; res_valid<=0.
- Latency and throughput:
  - Push at edge t on an idle, empty unit → ISSUE after t+1 → res_valid after t+2.
  - With res_ready=1 and a full queue, one result every 2 cycles.
- Pushes stay legal in every state, including during RESP stalls.
- Accumulator updates only at the ISSUE→RESP edge.
- ALU ports hold their last values outside ISSUE.
- Arithmetic: all 8-bit; carry comes solely from alu_c; no saturation; wrap-around is as the ALU produces it.
- FIFO pointers: log2(DEPTH) bits, wrap modulo DEPTH; count has log2(DEPTH)+1 bits.

Decomposition:
- Package alu_seq_pkg:
  - state enum {IDLE, ISSUE, RESP};
  - packed struct cmd_t {load, op[2:0], operand[7:0]};
  - opcode localparams: OP_ADD=000, OP_ADD_SHL=001, OP_SEL=010, OP_ADD_SHR=011, OP_ZERO=100, OP_OR=101, OP_AND=110, OP_SHL=111.
- Sub-module alu_cmd_fifo (DEPTH × cmd_t, push/pop/full/empty/count).
- FSM, accumulator and result registers live in the top.

Test Plan:
- Load 0x10, then OP_ADD 0x05, res_ready=1 (ALU attached) → results 0x10 (c0 z0), then 0x15 (c0 z0); acc=0x15; second res_valid exactly 2 cycles after the first handshake.
- Load 0xF0, then OP_ADD 0x20 → res_data=0x10, res_c=1, res_z=0.
- Load 0x0F, then OP_AND 0x30 → res_data=0x00, res_z=1; then OP_OR 0x81 → 0x81, z=0.
- Hold res_ready=0 and push DEPTH+1 commands → cmd_ready=0 once DEPTH are queued behind the active one; res_data stable; releasing res_ready drains all in order with correct accumulator chaining.
- Assert rst_n=0 while in ISSUE with 2 commands queued → immediate acc=0, res_valid=0, cmd_ready=1, busy=0; no result emitted after release.
- Load 0x00 → res_z=1, res_c=0, even when alu_z is forced 0 by the bench.
